mc_ctrl: RTL and testbench

- Multi-cycle control FSM for the MIPS datapath (PC, IR, register file, ALU, NPC, memory).
- Replaces the single-cycle decoder; emits the same control-signal encodings, qualified per state.
- Adds PC/IR write enables and a memory-ready handshake with timeout.
- Covers one instruction subset: R-type add/sub/and/or/slt/sltu/addu/subu/nor/sll/sllv/srl/srlv/jr/jalr; I-type addi/ori/andi/lui/slti/lw/sw/beq; J-type j/jal.

---
 rtl/mc_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mc_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: per-state qualified control fields,
// PC/IR write enables and a mem_rdy handshake with a bounded wait.
module mc_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_rdy,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       EXTOp,
  output logic [3:0] ALUOp,
  output logic [1:0] NPCOp,
  output logic [1:0] ALUSrc,
  output logic       SASrc,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel,
  output logic [2:0] state,
  output logic       illegal,
  output logic       bus_err
);

  // state  | meaning
  // FETCH  | read IR from mem[PC], PC <= PC+4 on mem_rdy
  // DECODE | resolve jumps, flag undecoded instructions
  // EXEC   | ALU operation, beq resolves here
  // MEM    | lw/sw data access at ALU address
  // WB     | register file write
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_wait;
  logic          w_abort;
  logic          w_wait_done;

  logic       w_j, w_jal, w_jr, w_jalr, w_beq, w_lw, w_sw, w_ralu, w_ialu, w_legal;
  logic [3:0] w_aluop;
  logic [1:0] w_alusrc;
  logic       w_sasrc, w_extop;

  always_comb begin
    w_j = 1'b0; w_jal = 1'b0; w_jr = 1'b0; w_jalr = 1'b0; w_beq = 1'b0;
    w_lw = 1'b0; w_sw = 1'b0; w_ralu = 1'b0; w_ialu = 1'b0;
    w_aluop = 4'd0; w_alusrc = 2'b00; w_sasrc = 1'b0; w_extop = 1'b0;
    if (Op == 6'h00) begin
      case (Funct)
        6'h20, 6'h21: begin w_ralu = 1'b1; w_aluop = 4'd1; end
        6'h22, 6'h23: begin w_ralu = 1'b1; w_aluop = 4'd2; end
        6'h24: begin w_ralu = 1'b1; w_aluop = 4'd3; end
        6'h25: begin w_ralu = 1'b1; w_aluop = 4'd4; end
        6'h27: begin w_ralu = 1'b1; w_aluop = 4'd7; end
        6'h2A: begin w_ralu = 1'b1; w_aluop = 4'd5; end
        6'h2B: begin w_ralu = 1'b1; w_aluop = 4'd6; end
        6'h00: begin w_ralu = 1'b1; w_aluop = 4'd8;  w_alusrc = 2'b10; end
        6'h04: begin w_ralu = 1'b1; w_aluop = 4'd8;  w_alusrc = 2'b10; w_sasrc = 1'b1; end
        6'h02: begin w_ralu = 1'b1; w_aluop = 4'd10; w_alusrc = 2'b10; end
        6'h06: begin w_ralu = 1'b1; w_aluop = 4'd10; w_alusrc = 2'b10; w_sasrc = 1'b1; end
        6'h08: w_jr = 1'b1;
        6'h09: w_jalr = 1'b1;
        default: ;
      endcase
    end else begin
      case (Op)
        6'h08: begin w_ialu = 1'b1; w_aluop = 4'd1; w_alusrc = 2'b01; w_extop = 1'b1; end
        6'h0C: begin w_ialu = 1'b1; w_aluop = 4'd3; w_alusrc = 2'b01; end
        6'h0D: begin w_ialu = 1'b1; w_aluop = 4'd4; w_alusrc = 2'b01; end
        6'h0A: begin w_ialu = 1'b1; w_aluop = 4'd5; w_alusrc = 2'b01; w_extop = 1'b1; end
        6'h0F: begin w_ialu = 1'b1; w_aluop = 4'd9; w_alusrc = 2'b01; end
        6'h23: begin w_lw = 1'b1; w_aluop = 4'd1; w_alusrc = 2'b01; w_extop = 1'b1; end
        6'h2B: begin w_sw = 1'b1; w_aluop = 4'd1; w_alusrc = 2'b01; w_extop = 1'b1; end
        6'h04: begin w_beq = 1'b1; w_aluop = 4'd2; w_extop = 1'b1; end
        6'h02: w_j = 1'b1;
        6'h03: w_jal = 1'b1;
        default: ;
      endcase
    end
    w_legal = w_j | w_jal | w_jr | w_jalr | w_beq | w_lw | w_sw | w_ralu | w_ialu;
  end

  assign w_wait_done = (TIMEOUT != 0) && (r_wait == CW'(TIMEOUT));

  always_comb begin
    w_next = r_state;
    w_abort = 1'b0;
    PCWrite = 1'b0; IRWrite = 1'b0; RegWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    IorD = 1'b0; EXTOp = 1'b0; ALUOp = 4'd0; NPCOp = 2'd0; ALUSrc = 2'b00;
    SASrc = 1'b0; GPRSel = 2'd0; WDSel = 2'd0; illegal = 1'b0; bus_err = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        if (mem_rdy) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          w_next  = S_DECODE;
        end else if (w_wait_done) begin
          bus_err = 1'b1;
          w_abort = 1'b1;
        end
      end
      S_DECODE: begin
        w_next = S_FETCH;
        if (w_j || w_jal) begin
          PCWrite = 1'b1;
          NPCOp   = 2'd2;
          if (w_jal) begin RegWrite = 1'b1; GPRSel = 2'd2; WDSel = 2'd2; end
        end else if (w_jr || w_jalr) begin
          PCWrite = 1'b1;
          NPCOp   = 2'd3;
          if (w_jalr) begin RegWrite = 1'b1; GPRSel = 2'd0; WDSel = 2'd2; end
        end else if (!w_legal) begin
          illegal = 1'b1;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        ALUOp = w_aluop; ALUSrc = w_alusrc; SASrc = w_sasrc; EXTOp = w_extop;
        if (w_beq) begin
          PCWrite = Zero;
          NPCOp   = 2'd1;
          w_next  = S_FETCH;
        end else if (w_lw || w_sw) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        IorD = 1'b1; ALUOp = 4'd1; ALUSrc = 2'b01; EXTOp = 1'b1;
        MemRead  = w_lw;
        MemWrite = w_sw;
        if (mem_rdy) begin
          w_next = w_lw ? S_WB : S_FETCH;
        end else if (w_wait_done) begin
          bus_err = 1'b1;
          w_abort = 1'b1;
          w_next  = S_FETCH;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        ALUOp = w_aluop; ALUSrc = w_alusrc; SASrc = w_sasrc; EXTOp = w_extop;
        GPRSel = w_ralu ? 2'd0 : 2'd1;
        WDSel  = w_lw ? 2'd1 : 2'd0;
        w_next = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    // Reset overrides any in-flight state so nothing is written during it.
    if (rst) begin
      PCWrite = 1'b0; IRWrite = 1'b0; RegWrite = 1'b0; MemWrite = 1'b0;
      illegal = 1'b0; bus_err = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state || w_abort) r_wait <= '0;
      else                              r_wait <= r_wait + CW'(1);
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: expected per-cycle output traces are built from the
// instruction's phase sequence (fetch, decode, exec, mem, wb) and wait counts.
module tb_mc_ctrl;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst, Zero, mem_rdy;
  logic [5:0] Op, Funct;
  logic       PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, EXTOp, SASrc;
  logic [3:0] ALUOp;
  logic [1:0] NPCOp, ALUSrc, GPRSel, WDSel;
  logic [2:0] state;
  logic       illegal, bus_err;

  mc_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_rdy(mem_rdy),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .IorD(IorD), .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp),
    .ALUSrc(ALUSrc), .SASrc(SASrc), .GPRSel(GPRSel), .WDSel(WDSel), .state(state),
    .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, irw, rw, mr, mw, iord, ext;
    logic [3:0] aluop;
    logic [1:0] npc, alusrc;
    logic       sas;
    logic [1:0] gpr, wds;
    logic [2:0] st;
    logic       ill, berr;
  } outs_t;

  typedef struct packed {
    logic  rdy;
    outs_t exp;
  } ent_t;

  outs_t dut_o;
  assign dut_o = {PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, EXTOp, ALUOp,
                  NPCOp, ALUSrc, SASrc, GPRSel, WDSel, state, illegal, bus_err};

  ent_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam int K_ILL = 0, K_J = 1, K_JAL = 2, K_JR = 3, K_JALR = 4;
  localparam int K_BEQ = 5, K_LW = 6, K_SW = 7, K_R = 8, K_I = 9;

  // Instruction table: class plus the single-cycle ALU-side encodings.
  function automatic void ref_decode(input logic [5:0] op, input logic [5:0] funct,
                                     output int kind, output logic [3:0] alu,
                                     output logic [1:0] src, output logic sas,
                                     output logic ext);
    kind = K_ILL; alu = 4'd0; src = 2'b00; sas = 1'b0; ext = 1'b0;
    if (op == 6'h00) begin
      case (funct)
        6'h20, 6'h21: begin kind = K_R; alu = 4'd1; end
        6'h22, 6'h23: begin kind = K_R; alu = 4'd2; end
        6'h24: begin kind = K_R; alu = 4'd3; end
        6'h25: begin kind = K_R; alu = 4'd4; end
        6'h27: begin kind = K_R; alu = 4'd7; end
        6'h2A: begin kind = K_R; alu = 4'd5; end
        6'h2B: begin kind = K_R; alu = 4'd6; end
        6'h00: begin kind = K_R; alu = 4'd8;  src = 2'b10; end
        6'h04: begin kind = K_R; alu = 4'd8;  src = 2'b10; sas = 1'b1; end
        6'h02: begin kind = K_R; alu = 4'd10; src = 2'b10; end
        6'h06: begin kind = K_R; alu = 4'd10; src = 2'b10; sas = 1'b1; end
        6'h08: kind = K_JR;
        6'h09: kind = K_JALR;
        default: kind = K_ILL;
      endcase
    end else begin
      case (op)
        6'h08: begin kind = K_I;  alu = 4'd1; src = 2'b01; ext = 1'b1; end
        6'h0C: begin kind = K_I;  alu = 4'd3; src = 2'b01; end
        6'h0D: begin kind = K_I;  alu = 4'd4; src = 2'b01; end
        6'h0A: begin kind = K_I;  alu = 4'd5; src = 2'b01; ext = 1'b1; end
        6'h0F: begin kind = K_I;  alu = 4'd9; src = 2'b01; end
        6'h23: begin kind = K_LW; alu = 4'd1; src = 2'b01; ext = 1'b1; end
        6'h2B: begin kind = K_SW; alu = 4'd1; src = 2'b01; ext = 1'b1; end
        6'h04: begin kind = K_BEQ; alu = 4'd2; ext = 1'b1; end
        6'h02: kind = K_J;
        6'h03: kind = K_JAL;
        default: kind = K_ILL;
      endcase
    end
  endfunction

  task automatic push(input logic rdy, input outs_t e);
    ent_t x;
    x.rdy = rdy;
    x.exp = e;
    q.push_back(x);
  endtask

  function automatic logic rnd_bit();
    return logic'($urandom_range(0, 1));
  endfunction

  // Expected trace for one instruction: fw/mw are the not-ready cycles seen
  // in FETCH/MEM before mem_rdy rises; TO waits end the access with bus_err.
  task automatic build_seq(input logic [5:0] op, input logic [5:0] funct,
                           input logic zero, input int fw, input int mw);
    int kind;
    logic [3:0] alu;
    logic [1:0] src;
    logic sas, ext;
    outs_t e;
    ref_decode(op, funct, kind, alu, src, sas, ext);
    for (int i = 0; i <= fw; i++) begin
      e = '0; e.st = 3'd0; e.mr = 1'b1;
      if (i == fw) begin e.irw = 1'b1; e.pcw = 1'b1; push(1'b1, e); end
      else if (i == TO) begin e.berr = 1'b1; push(1'b0, e); return; end
      else push(1'b0, e);
    end
    e = '0; e.st = 3'd1;
    case (kind)
      K_J:    begin e.pcw = 1'b1; e.npc = 2'd2; end
      K_JAL:  begin e.pcw = 1'b1; e.npc = 2'd2; e.rw = 1'b1; e.gpr = 2'd2; e.wds = 2'd2; end
      K_JR:   begin e.pcw = 1'b1; e.npc = 2'd3; end
      K_JALR: begin e.pcw = 1'b1; e.npc = 2'd3; e.rw = 1'b1; e.gpr = 2'd0; e.wds = 2'd2; end
      K_ILL:  e.ill = 1'b1;
      default: ;
    endcase
    push(rnd_bit(), e);
    if (kind == K_ILL || kind == K_J || kind == K_JAL || kind == K_JR || kind == K_JALR) return;
    e = '0; e.st = 3'd2; e.aluop = alu; e.alusrc = src; e.sas = sas; e.ext = ext;
    if (kind == K_BEQ) begin e.pcw = zero; e.npc = 2'd1; end
    push(rnd_bit(), e);
    if (kind == K_BEQ) return;
    if (kind == K_LW || kind == K_SW) begin
      for (int i = 0; i <= mw; i++) begin
        e = '0; e.st = 3'd3; e.iord = 1'b1; e.aluop = 4'd1; e.alusrc = 2'b01; e.ext = 1'b1;
        e.mr = (kind == K_LW); e.mw = (kind == K_SW);
        if (i == mw) push(1'b1, e);
        else if (i == TO) begin e.berr = 1'b1; push(1'b0, e); return; end
        else push(1'b0, e);
      end
      if (kind == K_SW) return;
    end
    e = '0; e.st = 3'd4; e.rw = 1'b1; e.aluop = alu; e.alusrc = src; e.sas = sas; e.ext = ext;
    e.gpr = (kind == K_R) ? 2'd0 : 2'd1;
    e.wds = (kind == K_LW) ? 2'd1 : 2'd0;
    push(rnd_bit(), e);
  endtask

  // New IR contents appear just after the edge that leaves the previous instruction.
  task automatic set_instr(input logic [5:0] op, input logic [5:0] funct, input logic zero);
    @(posedge clk);
    #1;
    rst = 1'b0; Op = op; Funct = funct; Zero = zero;
  endtask

  task automatic step(input logic rdy);
    @(negedge clk);
    mem_rdy = rdy;
    #1;
  endtask

  task automatic pick_instr(input int idx, output logic [5:0] op, output logic [5:0] funct);
    logic [5:0] rnd;
    rnd = 6'($urandom_range(0, 63));
    op = 6'h00; funct = rnd;
    case (idx)
      0: funct = 6'h20;  1: funct = 6'h21;  2: funct = 6'h22;  3: funct = 6'h23;
      4: funct = 6'h24;  5: funct = 6'h25;  6: funct = 6'h27;  7: funct = 6'h2A;
      8: funct = 6'h2B;  9: funct = 6'h00; 10: funct = 6'h04; 11: funct = 6'h02;
      12: funct = 6'h06; 13: funct = 6'h08; 14: funct = 6'h09;
      15: op = 6'h08; 16: op = 6'h0C; 17: op = 6'h0D; 18: op = 6'h0A; 19: op = 6'h0F;
      20: op = 6'h23; 21: op = 6'h2B; 22: op = 6'h04; 23: op = 6'h02; 24: op = 6'h03;
      25: op = 6'h3F; 26: op = 6'h05;
      default: funct = 6'h01;
    endcase
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_rdy = 1'b1; Op = 6'h00; Funct = 6'h21; Zero = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (state !== 3'd0 || {PCWrite, IRWrite, RegWrite, MemWrite, illegal, bus_err} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset: state=%0d we/pulses=%b, required state=0 we/pulses=000000",
                 state, {PCWrite, IRWrite, RegWrite, MemWrite, illegal, bus_err});
      end
    end
  endtask

  task automatic test_addu();
    set_instr(6'h00, 6'h21, 1'b0);
    build_seq(6'h00, 6'h21, 1'b0, 0, 0);
    while (q.size() > 0) begin
      ent_t x = q.pop_front();
      step(x.rdy);
      n_checks++;
      if (dut_o !== x.exp) begin
        n_fail++;
        $display("FAIL addu: got %h required %h (state %0d)", dut_o, x.exp, x.exp.st);
      end
    end
  endtask

  task automatic test_lw_wait();
    set_instr(6'h23, 6'h15, 1'b0);
    build_seq(6'h23, 6'h15, 1'b0, 0, 3);
    while (q.size() > 0) begin
      ent_t x = q.pop_front();
      step(x.rdy);
      n_checks++;
      if (dut_o !== x.exp) begin
        n_fail++;
        $display("FAIL lw_wait: got %h required %h (state %0d)", dut_o, x.exp, x.exp.st);
      end
    end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      set_instr(6'h04, 6'h3A, logic'(z));
      build_seq(6'h04, 6'h3A, logic'(z), 1, 0);
      while (q.size() > 0) begin
        ent_t x = q.pop_front();
        step(x.rdy);
        n_checks++;
        if (dut_o !== x.exp) begin
          n_fail++;
          $display("FAIL beq zero=%0d: got %h required %h (state %0d)", z, dut_o, x.exp, x.exp.st);
        end
      end
    end
  endtask

  task automatic test_jal_illegal();
    logic [5:0] ops [2];
    ops[0] = 6'h03; ops[1] = 6'h3F;
    for (int k = 0; k < 2; k++) begin
      set_instr(ops[k], 6'h00, 1'b0);
      build_seq(ops[k], 6'h00, 1'b0, 0, 0);
      while (q.size() > 0) begin
        ent_t x = q.pop_front();
        step(x.rdy);
        n_checks++;
        if (dut_o !== x.exp) begin
          n_fail++;
          $display("FAIL jal_illegal op=%h: got %h required %h", ops[k], dut_o, x.exp);
        end
      end
    end
  endtask

  // Wait counts straddling the limit in both FETCH and MEM.
  task automatic test_timeout();
    int fws [4];
    int mws [4];
    fws[0] = 0; mws[0] = 10;
    fws[1] = 0; mws[1] = TO - 1;
    fws[2] = TO; mws[2] = 0;
    fws[3] = TO - 1; mws[3] = TO;
    for (int k = 0; k < 4; k++) begin
      set_instr(6'h2B, 6'h00, 1'b0);
      build_seq(6'h2B, 6'h00, 1'b0, fws[k], mws[k]);
      while (q.size() > 0) begin
        ent_t x = q.pop_front();
        step(x.rdy);
        n_checks++;
        if (dut_o !== x.exp) begin
          n_fail++;
          $display("FAIL timeout fw=%0d mw=%0d: got %h required %h", fws[k], mws[k], dut_o, x.exp);
        end
      end
    end
  endtask

  task automatic test_reset_midwait();
    set_instr(6'h2B, 6'h00, 1'b0);
    step(1'b1); step(1'b0); step(1'b0); step(1'b0); step(1'b0);
    @(negedge clk);
    rst = 1'b1; mem_rdy = 1'b1;
    #1;
    n_checks++;
    if (state !== 3'd3 || {MemWrite, PCWrite, RegWrite, IRWrite, bus_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_mem: state=%0d we=%b, required state=3 we=00000",
               state, {MemWrite, PCWrite, RegWrite, IRWrite, bus_err});
    end
    set_instr(6'h00, 6'h25, 1'b0);
    step(1'b1);
    n_checks++;
    if (state !== 3'd0 || MemRead !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_recover: state=%0d MemRead=%b, required state=0 MemRead=1", state, MemRead);
    end
    step(1'b0); step(1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (state !== 3'd4 || RegWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wb: state=%0d RegWrite=%b, required state=4 RegWrite=0", state, RegWrite);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] op, funct;
    logic zero;
    for (int n = 0; n < 80; n++) begin
      pick_instr($urandom_range(0, 27), op, funct);
      zero = rnd_bit();
      set_instr(op, funct, zero);
      build_seq(op, funct, zero, $urandom_range(0, 5), $urandom_range(0, 5));
      while (q.size() > 0) begin
        ent_t x = q.pop_front();
        step(x.rdy);
        n_checks++;
        if (dut_o !== x.exp) begin
          n_fail++;
          $display("FAIL random #%0d op=%h funct=%h: got %h required %h",
                   n, op, funct, dut_o, x.exp);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_addu();
    test_lw_wait();
    test_beq();
    test_jal_illegal();
    test_timeout();
    test_reset_midwait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
